// File: rtl/generic_fifo_rdpf_crgn.sv
// generic_fifo_rdpf_crgn: read-side prefetch for the 1r1w FIFO.
// Issues reads ahead of demand and absorbs memory latency in a small buffer.
module generic_fifo_rdpf_crgn #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_op,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_count,
  output logic                  err_ovf
);

  localparam int         OB_DEPTH = RD_LAT + 2;
  localparam logic [2:0] LAST     = 3'(OB_DEPTH - 1);
  localparam logic [2:0] FULL     = 3'(OB_DEPTH);
  localparam logic [3:0] LIMIT    = 4'(OB_DEPTH);

  logic [RD_LAT-1:0]     infl_q, infl_d;
  logic [DATA_WIDTH-1:0] buf_q [OB_DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [OB_DEPTH];
  logic [2:0]            wr_ptr_q, wr_ptr_d;
  logic [2:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic       ret;
  logic       pop;
  logic       drop;
  logic       cap;
  logic [3:0] inflight;
  logic [3:0] occ;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == LAST) ? 3'd0 : p + 3'd1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {3'd0, infl_q[i]};
    end
  end

  // Issue only from registered state, so out_ready never reaches rd_op.
  assign occ        = {1'b0, cnt_q} + inflight;
  assign fifo_rd_op = reset_n & ~fifo_empty & ~clr & (occ < LIMIT);

  assign ret       = infl_q[RD_LAT-1];
  assign out_valid = (cnt_q != 3'd0);
  assign pop       = out_valid & out_ready;
  assign drop      = ret & (cnt_q == FULL) & ~pop;
  assign cap       = ret & ~drop;
  assign out_count = cnt_q;
  assign err_ovf   = err_q;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < OB_DEPTH; i++) begin
      if (rd_ptr_q == 3'(i)) out_data = buf_q[i];
    end
  end

  always_comb begin
    infl_d    = '0;
    infl_d[0] = fifo_rd_op;
    for (int i = 1; i < RD_LAT; i++) begin
      infl_d[i] = infl_q[i-1];
    end
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    if (clr) begin
      infl_d   = '0;
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      cnt_d    = 3'd0;
    end else begin
      if (cap) begin
        for (int i = 0; i < OB_DEPTH; i++) begin
          if (wr_ptr_q == 3'(i)) buf_d[i] = mem_rd_data;
        end
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + {2'd0, cap} - {2'd0, pop};
      err_d = drop;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      infl_q   <= '0;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      cnt_q    <= 3'd0;
      err_q    <= 1'b0;
      for (int i = 0; i < OB_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      infl_q   <= infl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: doc/generic_fifo_rdpf_crgn.md
# generic_fifo_rdpf_crgn

Read-side prefetch engine for the single-clock FIFO built from the generic pointer controller plus a compiled 1r1w memory. It drives the controller's read request, absorbs the memory's fixed read latency, and presents FIFO data as a valid/ready stream with full throughput and lossless backpressure. It sits between the FIFO pointer controller and memory read port on one side and the consuming logic on the other.

## Interface
- DATA_WIDTH, 32, width of memory read data and output stream
- RD_LAT, 1, memory read latency in cycles (legal 1..4); data for a read issued in cycle t is valid on mem_rd_data in cycle t+RD_LAT
- OB_DEPTH, RD_LAT+2 (derived, not overridable), output buffer entries (3..6)

- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- clr  in  1  flush; asserted in the same cycle as the pointer controller's clr
- fifo_empty  in  1  empty flag from pointer controller
- fifo_rd_op  out  1  read request to pointer controller rd_op and memory read enable (memory samples controller rd_addr in the same cycle)
- mem_rd_data  in  DATA_WIDTH  memory read data
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  consumer accepts word when out_valid && out_ready (pop)
- out_data  out  DATA_WIDTH  head word of output buffer
- out_count  out  3  words currently held in output buffer (0..OB_DEPTH)
- err_ovf  out  1  one-cycle pulse: a word returned while buffer was full and no pop (must never occur)

## Operation
- Reset (reset_n=0 at a clk edge): fifo_rd_op=0, out_valid=0, out_data=0, out_count=0, err_ovf=0; buffer entries, pointers, in-flight pipe cleared.
- In-flight tracking: shift register infl_pipe[RD_LAT-1:0]; bit 0 loads fifo_rd_op each cycle; ret = infl_pipe[RD_LAT-1] marks mem_rd_data valid this cycle. inflight = popcount(infl_pipe).
- Issue rule (combinational, registered-only inputs plus fifo_empty/clr): fifo_rd_op = !fifo_empty && !clr && (out_count + inflight < OB_DEPTH), compared in 4 bits. No combinational path from out_ready to fifo_rd_op.
- fifo_rd_op never asserts while fifo_empty=1, so the controller's read-on-empty error never fires.
- Capture: when ret=1, mem_rd_data written to buf[wr_ptr] at end of that cycle; wr_ptr increments, wrapping OB_DEPTH-1 -> 0 (non-power-of-2 depth supported).
- Pop: when out_valid && out_ready, rd_ptr increments with same wrap.
- out_count next = out_count + ret - pop; out_valid = (out_count != 0); out_data = buf[rd_ptr] (mux of buffer registers; no path from mem_rd_data).
- Ordering: words emerge in exact FIFO read order; no loss or duplication.
- err_ovf: registered, set for one cycle when ret && out_count==OB_DEPTH && !pop; the word is dropped. Unreachable by construction; bench checks it stays 0.
- clr: takes priority over all but reset. In clr cycle fifo_rd_op=0; at end of cycle out_count=0, pointers=0, infl_pipe=0. Returns for reads issued before clr are discarded. Buffer contents need not be zeroed; out_data is don't-care while out_valid=0.

## Timing
- Issue-to-out_valid latency: RD_LAT+1 cycles (issue in t, capture at end of t+RD_LAT, out_valid in t+RD_LAT+1).
- Throughput: 1 word/cycle sustained with out_ready=1 and fifo_empty=0, for every legal RD_LAT (OB_DEPTH=RD_LAT+2 covers RD_LAT in flight plus 1 held plus 1 slack).
- Backpressure: with out_ready=0, issue stops once out_count+inflight=OB_DEPTH; all in-flight words land without overflow.
- Simultaneous ret and pop with out_count=OB_DEPTH: legal, count unchanged, no err_ovf.
- Simultaneous clr and ret/pop: clr wins; pop in that cycle still counts as a consumer handshake of current out_data.
- Reset mid-operation: same as clr plus err_ovf=0 and out_data=0.

## Test plan
- Reset: hold reset_n=0 3 cycles with fifo_empty=0 -> fifo_rd_op, out_valid, out_count, err_ovf all 0 and out_data=0 throughout.
- Streaming, RD_LAT=2: 16 words preloaded, out_ready=1 -> fifo_rd_op high cycles 1..16 after reset release, out_valid from cycle 4, one word/cycle, data 0..15 in order.
- Backpressure, RD_LAT=2: out_ready=0 -> exactly 4 issues, out_count=4, fifo_rd_op stays 0; raise out_ready -> 4 words in order then streaming resumes, err_ovf=0.
- Empty: fifo_empty=1 for 20 cycles, out_ready=1 -> fifo_rd_op never asserts, out_valid stays 0.
- clr mid-flight, RD_LAT=3: issue 3 reads, clr in next cycle -> out_count=0, out_valid=0 for following 4 cycles, stale returns not presented; post-clr writes read back correctly.
- RD_LAT=4 random: random fifo_empty/out_ready over 10k cycles against 1r1w reference model -> scoreboard matches, out_count<=6, err_ovf never 1.
